// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one synchronous dual-port RAM port, one transaction in flight.
// Latency: request in IDLE -> ready 2 cycles later for writes, 3 cycles later for reads.
// Backpressure: requesters hold valid until their one-cycle ready pulse; valid is only sampled in IDLE.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: requester 0 always wins a simultaneous request.
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                r0_valid,
  input  logic [DATA_W/8-1:0] r0_wstrb,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  output logic                r0_ready,
  output logic [DATA_W-1:0]   r0_rdata,

  input  logic                r1_valid,
  input  logic [DATA_W/8-1:0] r1_wstrb,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  output logic                r1_ready,
  output logic [DATA_W-1:0]   r1_rdata,

  output logic [ADDR_W-1:0]   ext_dp_addr,
  output logic [DATA_W-1:0]   ext_dp_out,
  input  logic [DATA_W-1:0]   ext_dp_in,
  output logic                ext_dp_enable,
  output logic                ext_dp_write,

  output logic                busy,
  output logic                gnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LAT    = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                we_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_valid;
  logic                win;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

`ifndef MEM_ARB_FIXED_PRIO_EN
  // index of the requester granted most recently; reset to 1 so requester 0 goes first
  logic                last_gnt;
`endif

  // pick the winner among the requesters presenting valid this cycle
  always_comb begin
    any_valid = r0_valid | r1_valid;
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = ~r0_valid;
`else
    if (r0_valid && r1_valid) begin
      win = ~last_gnt;
    end else begin
      win = ~r0_valid;
    end
`endif
    sel_wstrb = win ? r1_wstrb : r0_wstrb;
    sel_addr  = win ? r1_addr  : r0_addr;
    sel_wdata = win ? r1_wdata : r0_wdata;
  end

  // state register; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state decode: reads take an extra cycle for the RAM's registered output
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = we_q ? RESP : LAT;
      LAT:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch the winning request and drive the registered RAM-side signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt           <= 1'b0;
      we_q          <= 1'b0;
      rdata_q       <= '0;
      ext_dp_addr   <= '0;
      ext_dp_out    <= '0;
      ext_dp_enable <= 1'b0;
      ext_dp_write  <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_gnt      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt           <= win;
            we_q          <= |sel_wstrb;
            // cleared so a write completes with zero read data
            rdata_q       <= '0;
            ext_dp_addr   <= sel_addr;
            ext_dp_out    <= sel_wdata;
            ext_dp_enable <= 1'b1;
            ext_dp_write  <= |sel_wstrb;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_gnt      <= win;
`endif
          end
        end
        ACCESS: begin
          ext_dp_enable <= 1'b0;
          ext_dp_write  <= 1'b0;
        end
        LAT: begin
          rdata_q <= ext_dp_in;
        end
        default: ;
      endcase
    end
  end

  // completion pulse and read data steered to the owner only
  always_comb begin
    r0_ready = (state == RESP) && !gnt;
    r1_ready = (state == RESP) && gnt;
    r0_rdata = r0_ready ? rdata_q : '0;
    r1_rdata = r1_ready ? rdata_q : '0;
    busy     = (state != IDLE);
  end

endmodule
